// File: rtl/shift_pkg.sv
// Shared constants and FSM encoding for the lane-based right shifter.
package shift_pkg;

  localparam int LANE_W   = 5;
  localparam int LANES    = 10;
  localparam int MAX_STEP = 4;
  localparam int DATA_W   = LANE_W * LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Lanes moved in one SHIFT cycle: min(remaining, MAX_STEP).
  function automatic logic [2:0] step_of(input logic [3:0] remaining);
    if (remaining > 4'(MAX_STEP)) return 3'(MAX_STEP);
    else                          return remaining[2:0];
  endfunction

endpackage

// File: rtl/lane_shift_step.sv
// Combinational 0..4-lane right shift; vacated upper lanes take the fill value.
module lane_shift_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        step_i,
  input  logic [LANE_W-1:0] fill_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i + int'(step_i) < LANES) begin
        data_o[i*LANE_W +: LANE_W] = data_i[(i + int'(step_i))*LANE_W +: LANE_W];
      end else begin
        data_o[i*LANE_W +: LANE_W] = fill_i;
      end
    end
  end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle lane right shifter: up to MAX_STEP lanes per SHIFT cycle, result held in DONE.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid is held with stable payload until that edge, and ready never depends on valid.
module shift_right_seq
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [49:0]       req_data,
  input  logic [3:0]        req_amount,
  input  logic [4:0]        req_fill,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [49:0]       resp_data,
  output logic              resp_err,
  output logic [1:0]        dbg_state
);

  state_t            state_q, state_d;
  logic [3:0]        rem_q, rem_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [LANE_W-1:0] fill_q, fill_d;
  logic              err_q, err_d;

  logic [2:0]        step;
  logic [3:0]        rem_after;
  logic [DATA_W-1:0] shifted;

  assign step      = step_of(rem_q);
  assign rem_after = rem_q - {1'b0, step};

  lane_shift_step u_step (
    .data_i (work_q),
    .step_i (step),
    .fill_i (fill_q),
    .data_o (shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      work_q  <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    work_d  = work_q;
    fill_d  = fill_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          work_d = req_data;
          fill_d = req_fill;
          rem_d  = req_amount;
          err_d  = 1'b0;
          if (req_amount == 4'd0) begin
            state_d = DONE;
          end else if (req_amount > 4'(LANES)) begin
            // Out-of-range amounts shift everything out: answer directly with all-fill.
            work_d  = {LANES{req_fill}};
            rem_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_after;
        if (rem_after == 4'd0) state_d = DONE;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_data  = work_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed scoreboard bench for shift_right_seq: driver pushes expected results, monitor pops on response.
module tb_shift_right_seq;
  import shift_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [49:0] req_data;
  logic [3:0]  req_amount;
  logic [4:0]  req_fill;
  logic        resp_valid;
  logic        resp_ready;
  logic [49:0] resp_data;
  logic        resp_err;
  logic [1:0]  dbg_state;

  int tests  = 0;
  int fails  = 0;
  int accepts = 0;
  int resps  = 0;
  bit gap_chk = 0;

  logic [50:0] exp_q[$];

  shift_right_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amount (req_amount),
    .req_fill   (req_fill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [49:0] lanes(input logic [4:0] a0, a1, a2, a3, a4,
                                        a5, a6, a7, a8, a9);
    return {a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (gap_chk) begin
        gap_chk = 0;
        check("idle_gap_after_resp", {62'd0, req_ready, resp_valid}, 64'b10);
      end
      if (req_valid && req_ready) accepts++;
      if (resp_valid && resp_ready) begin
        resps++;
        gap_chk = 1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got data 0x%0h err %0b, expected none", resp_data, resp_err);
        end else begin
          logic [50:0] e;
          e = exp_q.pop_front();
          check("resp_data", {14'd0, resp_data}, {14'd0, e[49:0]});
          check("resp_err", {63'd0, resp_err}, {63'd0, e[50]});
        end
      end
    end
  end

  // driver tasks
  task automatic wait_accept(output bit ok);
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready low for 50 cycles, expected high");
    end
  endtask

  // Latency = rising edges after the accept edge before resp_valid is seen high.
  task automatic wait_resp(input int exp_lat, input string name);
    int lat;
    for (lat = 0; lat < 20; lat++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    check(name, 64'(lat), 64'(exp_lat));
  endtask

  task automatic do_req(input logic [49:0] d, input logic [3:0] amt, input logic [4:0] f,
                        input logic [49:0] exp_d, input logic exp_e, input int exp_lat,
                        input string name);
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_data = d; req_amount = amt; req_fill = f;
    wait_accept(ok);
    if (ok) begin
      exp_q.push_back({exp_e, exp_d});
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_resp(exp_lat, name);
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  logic [49:0] dseq;
  logic [49:0] exp_stall;

  initial begin
    bit ok;
    int acc0, rsp0;
    dseq = lanes(5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A);
    rst = 1'b1; resp_ready = 1'b1;
    // request held during reset: reset must win
    req_valid = 1'b1; req_data = dseq; req_amount = 4'd0; req_fill = 5'h07;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    check("reset_outputs", {12'd0, req_ready, resp_valid, resp_err, resp_data},
          {12'd0, 1'b1, 1'b0, 1'b0, 50'd0});
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;

    do_req(dseq, 4'd3, 5'h1F,
           lanes(5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h1F, 5'h1F, 5'h1F),
           1'b0, 1, "lat_amt3");
    do_req(dseq, 4'd10, 5'h0A, {10{5'h0A}}, 1'b0, 3, "lat_amt10");
    do_req(dseq, 4'd0, 5'h07, dseq, 1'b0, 0, "lat_amt0");
    do_req(dseq, 4'd12, 5'h15, {10{5'h15}}, 1'b1, 0, "lat_amt12");
    do_req(lanes(5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00),
           4'd4, 5'h00,
           lanes(5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00),
           1'b0, 1, "lat_amt4");
    do_req(dseq, 4'd5, 5'h03,
           lanes(5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h03, 5'h03, 5'h03, 5'h03, 5'h03),
           1'b0, 2, "lat_amt5");
    do_req(dseq, 4'd15, 5'h1E, {10{5'h1E}}, 1'b1, 0, "lat_amt15");
    do_req(dseq, 4'd1, 5'h11,
           lanes(5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h11),
           1'b0, 1, "lat_amt1");
    do_req(dseq, 4'd9, 5'h00,
           lanes(5'h0A, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00),
           1'b0, 3, "lat_amt9");
    drain();

    // stall in DONE with junk requests present
    exp_stall = lanes(5'h07, 5'h08, 5'h09, 5'h0A, 5'h1C, 5'h1C, 5'h1C, 5'h1C, 5'h1C, 5'h1C);
    resp_ready = 1'b0;
    do_req(dseq, 4'd6, 5'h1C, exp_stall, 1'b0, 2, "lat_amt6_stall");
    #1;
    req_valid = 1'b1; req_data = '1; req_amount = 4'd2; req_fill = 5'h05;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data", {14'd0, resp_data}, {14'd0, exp_stall});
      check("stall_hs", {62'd0, req_ready, resp_valid}, 64'b01);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_release", 64'(dbg_state), 64'(IDLE));
    drain();

    // reset during the second SHIFT cycle of amount 9
    @(posedge clk); #1;
    req_valid = 1'b1; req_data = dseq; req_amount = 4'd9; req_fill = 5'h04;
    rsp0 = resps;
    wait_accept(ok);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    check("abort_outputs", {12'd0, req_ready, resp_valid, resp_err, resp_data},
          {12'd0, 1'b1, 1'b0, 1'b0, 50'd0});
    repeat (4) @(negedge clk);
    check("abort_no_resp", 64'(resps - rsp0), 64'd0);

    // back-to-back with req_valid held high
    acc0 = accepts; rsp0 = resps;
    @(posedge clk); #1;
    req_valid = 1'b1; req_data = dseq; req_amount = 4'd2; req_fill = 5'h00;
    wait_accept(ok);
    exp_q.push_back({1'b0, lanes(5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
                                 5'h00, 5'h00)});
    @(posedge clk); #1;
    req_amount = 4'd7; req_fill = 5'h01;
    wait_accept(ok);
    exp_q.push_back({1'b0, lanes(5'h08, 5'h09, 5'h0A, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01,
                                 5'h01, 5'h01)});
    @(posedge clk); #1;
    req_amount = 4'd0; req_fill = 5'h1B;
    wait_accept(ok);
    exp_q.push_back({1'b0, dseq});
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    check("b2b_accepts", 64'(accepts - acc0), 64'd3);
    check("b2b_resps", 64'(resps - rsp0), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
